// File: rtl/hough_vote_gen.sv
// rtl/hough_vote_gen.sv - Hough voting front end: walks edge points, sweeps theta, emits (rho, theta) votes
module hough_vote_gen #(
    parameter int N_THETA = 180,
    parameter int W_THETA = 8,
    parameter int W_RHO   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        x_in,
    input  logic [15:0]        y_in,
    input  logic               end_point,
    output logic               point_reset,
    output logic               inc_address,
    output logic [W_THETA-1:0] theta,
    input  logic [15:0]        cos_in,
    input  logic [15:0]        sin_in,
    output logic               vote_valid,
    input  logic               vote_ready,
    output logic [W_RHO-1:0]   vote_rho,
    output logic [W_THETA-1:0] vote_theta,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT,
        S_SWEEP,
        S_NEXT,
        S_DRAIN
    } state_t;

    localparam logic [W_THETA-1:0] THETA_LAST = W_THETA'(N_THETA - 1);
    localparam int                 RHO_MAX_I  = (1 << (W_RHO - 1)) - 1;
    localparam logic signed [33:0] RHO_MAX    = $signed(34'(RHO_MAX_I));
    localparam logic signed [33:0] RHO_MIN    = $signed(34'(-RHO_MAX_I - 1));

    state_t                state_q, state_d;
    logic [W_THETA-1:0]    theta_q, theta_d;
    logic                  s1_valid_q;
    logic [W_THETA-1:0]    s1_theta_q;
    logic signed [32:0]    s1_px_q, s1_py_q;
    logic                  vote_valid_q;
    logic [W_RHO-1:0]      vote_rho_q;
    logic [W_THETA-1:0]    vote_theta_q;

    logic                  stall;
    logic                  issue;
    logic signed [32:0]    x_ext, y_ext, cos_ext, sin_ext, px_d, py_d;
    logic signed [33:0]    sum, rnd, r;
    logic [W_RHO-1:0]      rho_sat;

    assign stall = vote_valid_q & ~vote_ready;
    assign issue = (state_q == S_SWEEP) & ~stall;

    always_comb begin
        state_d     = state_q;
        theta_d     = theta_q;
        point_reset = 1'b0;
        inc_address = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLR;
            end
            S_CLR: begin
                point_reset = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                theta_d = '0;
                state_d = end_point ? S_DRAIN : S_SWEEP;
            end
            S_SWEEP: begin
                if (!stall) begin
                    if (theta_q == THETA_LAST) begin
                        theta_d = '0;
                        state_d = S_NEXT;
                    end else begin
                        theta_d = theta_q + W_THETA'(1);
                    end
                end
            end
            S_NEXT: begin
                inc_address = 1'b1;
                state_d     = S_WAIT;
            end
            S_DRAIN: begin
                if (!s1_valid_q && !vote_valid_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Coordinates are unsigned Q12.4, trig values signed Q2.14; products carry 18 fraction bits.
    assign x_ext   = {17'd0, x_in};
    assign y_ext   = {17'd0, y_in};
    assign cos_ext = {{17{cos_in[15]}}, cos_in};
    assign sin_ext = {{17{sin_in[15]}}, sin_in};
    assign px_d    = x_ext * cos_ext;
    assign py_d    = y_ext * sin_ext;

    assign sum = {s1_px_q[32], s1_px_q} + {s1_py_q[32], s1_py_q};
    assign rnd = sum + 34'sd131072;
    assign r   = rnd >>> 18;

    always_comb begin
        rho_sat = r[W_RHO-1:0];
        if (r > RHO_MAX)      rho_sat = {1'b0, {(W_RHO-1){1'b1}}};
        else if (r < RHO_MIN) rho_sat = {1'b1, {(W_RHO-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            theta_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_theta_q   <= '0;
            s1_px_q      <= '0;
            s1_py_q      <= '0;
            vote_valid_q <= 1'b0;
            vote_rho_q   <= '0;
            vote_theta_q <= '0;
        end else begin
            state_q <= state_d;
            theta_q <= theta_d;
            // Both pipeline stages advance together; a consumed output reloads from stage 1 in the same cycle.
            if (!stall) begin
                s1_valid_q <= issue;
                if (issue) begin
                    s1_theta_q <= theta_q;
                    s1_px_q    <= px_d;
                    s1_py_q    <= py_d;
                end
                vote_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    vote_rho_q   <= rho_sat;
                    vote_theta_q <= s1_theta_q;
                end
            end
        end
    end

    assign theta      = theta_q;
    assign vote_valid = vote_valid_q;
    assign vote_rho   = vote_rho_q;
    assign vote_theta = vote_theta_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_hough_vote_gen.sv
// tb/tb_hough_vote_gen.sv - randomized self-checking bench for hough_vote_gen against a vote-list model
module tb_hough_vote_gen;
    localparam int N_THETA = 180;
    localparam int W_THETA = 8;
    localparam int W_RHO   = 12;
    localparam int BUDGET  = 40000;

    logic               clk = 1'b0;
    logic               reset, start, end_point, point_reset, inc_address;
    logic               vote_valid, vote_ready, busy, done;
    logic [15:0]        x_in, y_in, cos_in, sin_in;
    logic [W_THETA-1:0] theta, vote_theta;
    logic [W_RHO-1:0]   vote_rho;

    always #5 clk = ~clk;

    hough_vote_gen #(.N_THETA(N_THETA), .W_THETA(W_THETA), .W_RHO(W_RHO)) dut (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
        .end_point(end_point), .point_reset(point_reset), .inc_address(inc_address),
        .theta(theta), .cos_in(cos_in), .sin_in(sin_in), .vote_valid(vote_valid),
        .vote_ready(vote_ready), .vote_rho(vote_rho), .vote_theta(vote_theta),
        .busy(busy), .done(done)
    );

    // Point source and trig ROM models
    logic [15:0]        xs [0:63];
    logic [15:0]        ys [0:63];
    logic signed [15:0] cos_tab [0:255];
    logic signed [15:0] sin_tab [0:255];
    int                 npts = 0;
    int                 addr = 0;

    always @(posedge clk) begin
        if (point_reset)      addr <= 0;
        else if (inc_address) addr <= addr + 1;
    end
    assign end_point = (addr >= npts);
    assign x_in      = (addr < npts) ? xs[addr] : 16'h0;
    assign y_in      = (addr < npts) ? ys[addr] : 16'h0;
    assign cos_in    = cos_tab[theta];
    assign sin_in    = sin_tab[theta];

    typedef struct { longint rho; longint th; } vote_t;
    vote_t exp_q[$];

    int checks = 0, failures = 0;
    int n_votes, n_inc, n_prst, n_done, n_overlap;
    longint obs_rho [0:255];

    task automatic check(input string tag, input longint obs, input longint exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Every vote of the frame, in order: points outer, theta inner, rounded and clamped rho.
    task automatic build_model(input int n);
        longint p, rr;
        vote_t  v;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < N_THETA; t++) begin
                p  = longint'(xs[i]) * longint'(cos_tab[t]) + longint'(ys[i]) * longint'(sin_tab[t]);
                rr = (p + 131072) >>> 18;
                if (rr > 2047)  rr = 2047;
                if (rr < -2048) rr = -2048;
                v.rho = rr;
                v.th  = t;
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic rand_tables();
        for (int t = 0; t < 256; t++) begin
            cos_tab[t] = 16'($urandom);
            sin_tab[t] = 16'($urandom);
        end
    endtask

    task automatic rand_points(input int n);
        for (int i = 0; i < n; i++) begin
            xs[i] = 16'($urandom);
            ys[i] = 16'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (inc_address) n_inc++;
            if (point_reset) n_prst++;
            if (done) n_done++;
            if (inc_address && point_reset) n_overlap++;
            if (vote_valid) begin
                if (exp_q.size() == 0) begin
                    check("vote_extra", 1, 0);
                end else begin
                    check("vote_rho", $signed(vote_rho), exp_q[0].rho);
                    check("vote_theta", vote_theta, exp_q[0].th);
                    if (vote_ready) begin
                        obs_rho[vote_theta] = $signed(vote_rho);
                        n_votes++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic clear_counts();
        n_votes = 0; n_inc = 0; n_prst = 0; n_done = 0; n_overlap = 0;
        for (int t = 0; t < 256; t++) obs_rho[t] = -99999;
    endtask

    task automatic run_frame(input int n, input int ready_pct, input bit restart_mid,
                             output int first_valid, output int done_k);
        int k;
        npts = n;
        build_model(n);
        clear_counts();
        first_valid = -1;
        done_k      = -1;
        @(posedge clk); #1;
        start      = 1'b1;
        vote_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k     = 0;
        check("busy_after_start", busy, 1);
        check("point_reset_clr", point_reset, 1);
        while (k < BUDGET && done_k < 0) begin
            @(posedge clk); #1;
            k++;
            if (vote_valid && first_valid < 0) first_valid = k;
            if (done) done_k = k;
            vote_ready = ($urandom_range(0, 99) < ready_pct);
            start      = (restart_mid && (k == 50 || k == 400));
        end
        start      = 1'b0;
        vote_ready = 1'b1;
        if (done_k < 0) check("frame_timeout", 0, 1);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("votes", n_votes, n * N_THETA);
        check("inc_pulses", n_inc, n);
        check("done_pulses", n_done, 1);
        check("point_reset_pulses", n_prst, 1);
        check("inc_prst_overlap", n_overlap, 0);
        check("leftover_votes", exp_q.size(), 0);
    endtask

    int fv, dk;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        vote_ready = 1'b1;
        rand_tables();
        rand_points(64);
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("rst_vote_valid", vote_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_point_reset", point_reset, 0);
        check("rst_inc_address", inc_address, 0);
        check("rst_theta", theta, 0);
        check("rst_vote_rho", vote_rho, 0);
        check("rst_vote_theta", vote_theta, 0);
        reset = 1'b0;

        // Directed: x=0, y=800 at theta 32
        rand_tables();
        cos_tab[32] = 16'sd13894;
        sin_tab[32] = 16'sd8682;
        xs[0] = 16'h0000;
        ys[0] = 16'h3200;
        run_frame(1, 100, 1'b0, fv, dk);
        check("first_vote_latency", fv, 4);
        check("rho_theta32", obs_rho[32], 424);

        // Directed: x=100, y=170 at theta 0 and 90
        rand_tables();
        cos_tab[0]  = 16'sd16384;
        sin_tab[0]  = 16'sd0;
        cos_tab[90] = 16'sd0;
        sin_tab[90] = 16'sd16384;
        xs[0] = 16'd1600;
        ys[0] = 16'd2720;
        run_frame(1, 70, 1'b0, fv, dk);
        check("rho_theta0", obs_rho[0], 100);
        check("rho_theta90", obs_rho[90], 170);

        // 30 random points, ready held high, then the same frame with back-pressure and stray starts
        rand_tables();
        rand_points(30);
        run_frame(30, 100, 1'b0, fv, dk);
        check("first_vote_latency_30", fv, 4);
        run_frame(30, 55, 1'b1, fv, dk);

        // Empty source: no votes, done soon after CLR
        run_frame(0, 100, 1'b0, fv, dk);
        check("empty_done_latency", (dk >= 0 && dk <= 3) ? 1 : 0, 1);

        // Reset mid-sweep, then a clean restart from point 0
        rand_tables();
        rand_points(10);
        npts = 10;
        build_model(10);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            vote_ready = ($urandom_range(0, 99) < 80);
        end
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_vote_valid", vote_valid, 0);
        check("mid_reset_busy", busy, 0);
        reset      = 1'b0;
        vote_ready = 1'b1;
        exp_q.delete();
        run_frame(10, 75, 1'b0, fv, dk);
        check("restart_first_vote_latency", fv, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
